// File: rtl/bcd_mod_counter_if.sv
// Signal bundle for bcd_mod_counter; ld/din exist only when BCD_CNT_LOAD_EN is defined.
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
);
  // en is a per-edge step strobe with no back-pressure: every rising clk edge
  // that sees en = 1 advances the count once. rco is the combinational
  // "this stage wraps on this edge" strobe used as the next stage's en.
  logic                en;
  logic                up;
`ifdef BCD_CNT_LOAD_EN
  logic                ld;
  logic [4*DIGITS-1:0] din;
`endif
  logic [4*DIGITS-1:0] bcd;
  logic                rco;
  logic                wrap;
  logic                err;

  modport master (
    output en, up,
`ifdef BCD_CNT_LOAD_EN
    output ld, din,
`endif
    input  bcd, rco, wrap, err
  );

  modport slave (
    input  en, up,
`ifdef BCD_CNT_LOAD_EN
    input  ld, din,
`endif
    output bcd, rco, wrap, err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Cascadable BCD modulo-MODULUS up/down counter with registered wrap pulse.
// Optional parallel load with range checking is enabled by BCD_CNT_LOAD_EN.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic             clk,
  input  logic             cr,
  bcd_mod_counter_if.slave bus
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  generate
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $fatal(1, "bcd_mod_counter: DIGITS must be 1..4");
    end
    if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_modulus
      $fatal(1, "bcd_mod_counter: MODULUS must be 2..10**DIGITS");
    end
  endgenerate

  logic [W-1:0] count;
  logic         wrap_q;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] load_val;
  logic         ld_eff;
  logic         at_max;
  logic         at_zero;
  logic         terminal;

  // Terminal is a whole-value compare so MODULUS need not align to digit limits.
  assign at_max   = (count == MAX_BCD);
  assign at_zero  = (count == '0);
  assign terminal = bus.up ? at_max : at_zero;

  always_comb begin : step_chain
    logic carry;
    logic borrow;
    carry   = 1'b1;
    borrow  = 1'b1;
    inc_val = count;
    dec_val = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

`ifdef BCD_CNT_LOAD_EN
  logic load_ok;
  logic err_q;

  // Invalid if any nibble is not a decimal digit or the value is out of range.
  always_comb begin : load_check
    logic [15:0] value;
    logic        digit_bad;
    value     = '0;
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.din[4*i +: 4] > 4'd9) digit_bad = 1'b1;
      value = value + 16'(bus.din[4*i +: 4]) * 16'(10**i);
    end
    load_ok  = !digit_bad && (value < 16'(MODULUS));
    load_val = load_ok ? bus.din : '0;
  end

  assign ld_eff = bus.ld;

  always_ff @(posedge clk or posedge cr) begin
    if (cr) begin
      err_q <= 1'b0;
    end else if (bus.ld) begin
      err_q <= ~load_ok;
    end
  end

  assign bus.err = err_q;
`else
  assign ld_eff   = 1'b0;
  assign load_val = '0;
  assign bus.err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge cr) begin
    if (cr) begin
      count  <= '0;
      wrap_q <= 1'b0;
    end else if (ld_eff) begin
      count  <= load_val;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      if (terminal) begin
        count  <= bus.up ? '0 : MAX_BCD;
        wrap_q <= 1'b1;
      end else begin
        count  <= bus.up ? inc_val : dec_val;
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.bcd  = count;
  assign bus.rco  = bus.en & ~ld_eff & terminal;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: seconds/minutes cascade, 3-digit day counter with
// random stimulus, and (with BCD_CNT_LOAD_EN) a mod-24 load test.
module tb_bcd_mod_counter;

  logic clk;
  logic cr;
  int   passed = 0;
  int   total  = 0;

  bcd_mod_counter_if #(.DIGITS(2)) s_if ();
  bcd_mod_counter_if #(.DIGITS(2)) m_if ();
  bcd_mod_counter_if #(.DIGITS(2)) h_if ();
  bcd_mod_counter_if #(.DIGITS(3)) d_if ();

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60))  u_sec (.clk(clk), .cr(cr), .bus(s_if.slave));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60))  u_min (.clk(clk), .cr(cr), .bus(m_if.slave));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(24))  u_hr  (.clk(clk), .cr(cr), .bus(h_if.slave));
  bcd_mod_counter #(.DIGITS(3), .MODULUS(365)) u_day (.clk(clk), .cr(cr), .bus(d_if.slave));

  assign m_if.en = s_if.rco;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    #2 cr = 1'b1;
    #1 cr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    else passed++;
  endtask

  function automatic logic [15:0] dec_to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = r | (16'((v / (10**i)) % 10) << (4 * i));
    return r;
  endfunction

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       rco;
    logic [7:0] bcd;
    logic       wrap;
  } vec_t;

  vec_t        vecs [12];
  logic [11:0] exp_q [$];
  int          cnt;
  int          prev;
  int          pulses;
  logic        dir;
  logic        exp_wrap;

  initial begin
    cr = 1'b0;
    s_if.en = 1'b0; s_if.up = 1'b1;
    m_if.up = 1'b1;
    h_if.en = 1'b0; h_if.up = 1'b1;
    d_if.en = 1'b0; d_if.up = 1'b1;
`ifdef BCD_CNT_LOAD_EN
    s_if.ld = 1'b0; s_if.din = '0;
    m_if.ld = 1'b0; m_if.din = '0;
    h_if.ld = 1'b0; h_if.din = '0;
    d_if.ld = 1'b0; d_if.din = '0;
`endif
    // rows: optional reset, inputs, rco before edge, bcd/wrap after edge
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h09, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h59, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h58, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h59, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h59, 1'b1};

    @(negedge clk);
    do_reset();
    check("reset_bcd", s_if.bcd, 8'h00);

    // asynchronous clear mid-count at 42
    s_if.en = 1'b1; s_if.up = 1'b1;
    repeat (42) tick();
    check("pre_clear_bcd", s_if.bcd, 8'h42);
    #2 cr = 1'b1;
    #1;
    check("clear_bcd", s_if.bcd, 8'h00);
    check("clear_wrap", s_if.wrap, 1'b0);
    check("clear_err", s_if.err, 1'b0);
    cr = 1'b0;
    tick();
    check("resume_bcd", s_if.bcd, 8'h01);

    // up wrap: 125 edges from 00
    do_reset();
    cnt = 0;
    for (int c = 0; c < 125; c++) begin
      #1;
      check("up_rco", s_if.rco, cnt == 59);
      tick();
      cnt = (cnt + 1) % 60;
      check("up_bcd", s_if.bcd, dec_to_bcd(cnt));
      check("up_wrap", s_if.wrap, cnt == 0);
    end

    // enable/direction from 09, then down/up wrap rows
    do_reset();
    repeat (9) tick();
    check("count_to_09", s_if.bcd, 8'h09);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) do_reset();
      s_if.en = vecs[i].en;
      s_if.up = vecs[i].up;
      #1;
      check($sformatf("vec%0d_rco", i), s_if.rco, vecs[i].rco);
      tick();
      check($sformatf("vec%0d_bcd", i), s_if.bcd, vecs[i].bcd);
      check($sformatf("vec%0d_wrap", i), s_if.wrap, vecs[i].wrap);
    end

    // cascade seconds -> minutes from 00:58
    do_reset();
    s_if.en = 1'b1; s_if.up = 1'b1;
    repeat (58) tick();
    check("casc_sec58", s_if.bcd, 8'h58);
    check("casc_min00", m_if.bcd, 8'h00);
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (m_if.en) pulses++;
      tick();
    end
    check("casc_sec00", s_if.bcd, 8'h00);
    check("casc_min01", m_if.bcd, 8'h01);
    check("casc_pulses", pulses, 1);
    s_if.en = 1'b0;

`ifdef BCD_CNT_LOAD_EN
    // load on mod-24 stage
    do_reset();
    h_if.en = 1'b1; h_if.up = 1'b1; h_if.ld = 1'b1; h_if.din = 8'h23;
    tick();
    check("ld23_bcd", h_if.bcd, 8'h23);
    check("ld23_err", h_if.err, 1'b0);
    h_if.din = 8'h1A;
    #1;
    check("ld_rco_mask", h_if.rco, 1'b0);
    tick();
    check("ld1A_bcd", h_if.bcd, 8'h00);
    check("ld1A_err", h_if.err, 1'b1);
    check("ld1A_wrap", h_if.wrap, 1'b0);
    h_if.din = 8'h25;
    tick();
    check("ld25_bcd", h_if.bcd, 8'h00);
    check("ld25_err", h_if.err, 1'b1);
    h_if.din = 8'h05;
    tick();
    check("ld05_bcd", h_if.bcd, 8'h05);
    check("ld05_err", h_if.err, 1'b0);
    h_if.ld = 1'b0;
    tick();
    check("after_ld_bcd", h_if.bcd, 8'h06);
    h_if.ld = 1'b1; h_if.din = 8'h23;
    tick();
    h_if.ld = 1'b0;
    #1;
    check("hr23_rco", h_if.rco, 1'b1);
    tick();
    check("hr_wrap_bcd", h_if.bcd, 8'h00);
    check("hr_wrap", h_if.wrap, 1'b1);
    h_if.ld = 1'b1; h_if.din = 8'h99;
    tick();
    check("ld99_err", h_if.err, 1'b1);
    h_if.ld = 1'b0; h_if.en = 1'b0;
    do_reset();
    check("cr_clears_err", h_if.err, 1'b0);
`endif

    // random walk on the 3-digit mod-365 counter against an integer model
    do_reset();
    cnt = 0;
    dir = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 499) == 0) dir = ~dir;
      d_if.up = dir;
      d_if.en = ($urandom_range(0, 7) != 0);
      #1;
      check("day_rco", d_if.rco, d_if.en && (d_if.up ? (cnt == 364) : (cnt == 0)));
      prev = cnt;
      if (d_if.en) cnt = d_if.up ? (cnt + 1) % 365 : (cnt + 364) % 365;
      exp_wrap = d_if.en && (d_if.up ? (cnt < prev) : (cnt > prev));
      exp_q.push_back(12'(dec_to_bcd(cnt)));
      tick();
      check("day_bcd", d_if.bcd, exp_q.pop_front());
      check("day_wrap", d_if.wrap, exp_wrap);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
